dft_axil_initiator: RTL and testbench
=====================================

// Module: dft_axil_initiator
// PURPOSE
//  AXI4-Lite master (initiator) converting a simple command/response stream into single AXI-Lite
//  read/write transactions. Drives the AXI_S_* slave port of the DFT accelerator; used by the
//  register-sequencing bench and by on-chip test logic that programs DFT registers without the PS.
//  One transaction outstanding at a time; responses return in command order.
// PARAMETERS
//  ADDR_WIDTH  24  AXI address width; must match the slave's ADDR_WIDTH.
//  PROT        3'b000  constant driven on AWPROT/ARPROT.
// PORTS
//  AXI_M_ACLK     in   1   sole clock; all logic rising-edge.
//  AXI_M_ARESETn  in   1   reset, asynchronous assert, active-low.
//  CMD_VALID      in   1   command present.
//  CMD_READY      out  1   command accepted when CMD_VALID&&CMD_READY.
//  CMD_WRITE      in   1   1=write, 0=read.
//  CMD_ADDR       in   ADDR_WIDTH  byte address (bits [1:0] forwarded unchanged).
//  CMD_WDATA      in   32  write data (ignored for reads).
//  CMD_WSTRB      in   4   byte strobes (ignored for reads).
//  RSP_VALID      out  1   response present.
//  RSP_READY      in   1   response consumed when RSP_VALID&&RSP_READY.
//  RSP_WRITE      out  1   echoes CMD_WRITE of the completed transaction.
//  RSP_RDATA      out  32  read data; 0 for writes.
//  RSP_RESP       out  2   BRESP or RRESP of the completed transaction.
//  AXI_M_AWVALID/AWREADY/AWADDR[ADDR_WIDTH]/AWPROT[3]  write address channel (master side).
//  AXI_M_WVALID/WREADY/WDATA[32]/WSTRB[4]              write data channel.
//  AXI_M_BVALID(in)/BREADY(out)/BRESP[2](in)           write response channel.
//  AXI_M_ARVALID/ARREADY/ARADDR[ADDR_WIDTH]/ARPROT[3]  read address channel.
//  AXI_M_RVALID(in)/RREADY(out)/RDATA[32](in)/RRESP[2](in)  read data channel.
// BEHAVIOUR
//  Reset (AXI_M_ARESETn=0, async): state IDLE; CMD_READY, RSP_VALID, AWVALID, WVALID, BREADY,
//   ARVALID, RREADY all 0; address/data/RSP_* registers 0. CMD_READY rises the first edge after release.
//  All outputs registered. States: IDLE, WR_REQ, WR_RESP, RD_REQ, RD_RESP, RSP.
//  IDLE: CMD_READY=1. On accept (edge N): latch addr/data/strb/write; CMD_READY=0;
//   write -> WR_REQ with AWVALID=WVALID=1 from edge N; read -> RD_REQ with ARVALID=1.
//  WR_REQ: AW and W handshakes tracked independently (aw_done, w_done); each VALID drops the edge
//   after its own handshake and never deasserts before it; either order or same cycle legal.
//   When both done -> WR_RESP with BREADY=1.
//  WR_RESP: on BVALID&&BREADY capture BRESP, BREADY=0, RDATA=0 -> RSP.
//  RD_REQ: on ARVALID&&ARREADY drop ARVALID, RREADY=1 -> RD_RESP.
//  RD_RESP: on RVALID&&RREADY capture RDATA/RRESP, RREADY=0 -> RSP.
//  RSP: RSP_VALID=1, RSP_* stable until RSP_READY; on handshake RSP_VALID=0, CMD_READY=1 -> IDLE.
//  Latency, zero-wait slave: accept at N, AW/W/AR handshake N+1, B/R at N+2 earliest,
//   RSP_VALID visible after edge N+3.
//  AXI outputs (ADDR/DATA/STRB) stable whenever the corresponding VALID is high.
//  No BVALID/RVALID outside the matching response state is legal; they are ignored (no capture).
//  SLVERR/DECERR passed through unmodified; no retry. No timeout: initiator waits indefinitely.
//  Reset mid-transaction: immediate return to IDLE, transaction dropped, no response generated.
// STRUCTURE
//  Package dft_axil_pkg: typedef enum axil_state_t {IDLE,WR_REQ,WR_RESP,RD_REQ,RD_RESP,RSP};
//   localparams RESP_OKAY=2'b00, RESP_EXOKAY=2'b01, RESP_SLVERR=2'b10, RESP_DECERR=2'b11.
//  Single flat module; no sub-module. Pairs with DFT_FPGA_WRAP via matching AXI signal names.
// TESTING
//  1 Write 0x000010<-0xDEADBEEF, WSTRB 4'hF, zero-wait slave -> AW/W at N+1, RSP_VALID after N+3,
//    RSP_WRITE=1, RSP_RESP=00, RSP_RDATA=0.
//  2 Write with AWREADY delayed 5 cycles, WREADY immediate -> WVALID drops after 1 handshake,
//    AWVALID held 5 cycles with AWADDR stable; exactly one B handshake.
//  3 Read 0x000020, slave returns RDATA=0x12345678 after 3-cycle RVALID delay ->
//    RSP_RDATA=0x12345678, RSP_RESP=00, RSP_WRITE=0.
//  4 Read with RRESP=2'b10 and RSP_READY held low 4 cycles -> RSP_RESP=10 held stable,
//    CMD_READY stays 0 until RSP handshake.
//  5 Back-to-back write then read with CMD_VALID held high -> second command accepted only
//    after first RSP handshake; order preserved.
//  6 Assert reset in WR_RESP -> all VALIDs/READYs 0 asynchronously, no RSP_VALID;
//    CMD_READY=1 one edge after release.

Source files
------------

// File: rtl/dft_axil_pkg.sv
// Shared types and constants for the DFT AXI4-Lite initiator.
package dft_axil_pkg;

    typedef enum logic [2:0] {
        IDLE,
        WR_REQ,
        WR_RESP,
        RD_REQ,
        RD_RESP,
        RSP
    } axil_state_t;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_EXOKAY = 2'b01;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] RESP_DECERR = 2'b11;

endpackage

// File: rtl/dft_axil_initiator.sv
// AXI4-Lite master: turns one command into one AXI-Lite transaction and returns
// its response in order. Single outstanding transaction, all outputs registered.
module dft_axil_initiator
    import dft_axil_pkg::*;
#(
    parameter int         ADDR_WIDTH = 24,
    parameter logic [2:0] PROT       = 3'b000
) (
    input  logic                  AXI_M_ACLK,
    input  logic                  AXI_M_ARESETn,
    input  logic                  CMD_VALID,
    output logic                  CMD_READY,
    input  logic                  CMD_WRITE,
    input  logic [ADDR_WIDTH-1:0] CMD_ADDR,
    input  logic [31:0]           CMD_WDATA,
    input  logic [3:0]            CMD_WSTRB,
    output logic                  RSP_VALID,
    input  logic                  RSP_READY,
    output logic                  RSP_WRITE,
    output logic [31:0]           RSP_RDATA,
    output logic [1:0]            RSP_RESP,
    output logic                  AXI_M_AWVALID,
    input  logic                  AXI_M_AWREADY,
    output logic [ADDR_WIDTH-1:0] AXI_M_AWADDR,
    output logic [2:0]            AXI_M_AWPROT,
    output logic                  AXI_M_WVALID,
    input  logic                  AXI_M_WREADY,
    output logic [31:0]           AXI_M_WDATA,
    output logic [3:0]            AXI_M_WSTRB,
    input  logic                  AXI_M_BVALID,
    output logic                  AXI_M_BREADY,
    input  logic [1:0]            AXI_M_BRESP,
    output logic                  AXI_M_ARVALID,
    input  logic                  AXI_M_ARREADY,
    output logic [ADDR_WIDTH-1:0] AXI_M_ARADDR,
    output logic [2:0]            AXI_M_ARPROT,
    input  logic                  AXI_M_RVALID,
    output logic                  AXI_M_RREADY,
    input  logic [31:0]           AXI_M_RDATA,
    input  logic [1:0]            AXI_M_RRESP
);

    axil_state_t           state, state_nxt;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic [31:0]           wdata_q;
    logic [3:0]            wstrb_q;
    logic                  aw_done, w_done;
    logic                  cmd_acc, aw_hs, w_hs, aw_fin, w_fin;

    assign cmd_acc = CMD_VALID && CMD_READY;
    assign aw_hs   = AXI_M_AWVALID && AXI_M_AWREADY;
    assign w_hs    = AXI_M_WVALID && AXI_M_WREADY;
    // A channel counts as finished if it completed earlier or is completing now.
    assign aw_fin  = aw_done || aw_hs;
    assign w_fin   = w_done || w_hs;

    assign AXI_M_AWADDR = addr_q;
    assign AXI_M_ARADDR = addr_q;
    assign AXI_M_WDATA  = wdata_q;
    assign AXI_M_WSTRB  = wstrb_q;
    assign AXI_M_AWPROT = PROT;
    assign AXI_M_ARPROT = PROT;

    always_ff @(posedge AXI_M_ACLK or negedge AXI_M_ARESETn) begin
        if (!AXI_M_ARESETn) state <= IDLE;
        else                state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (cmd_acc) state_nxt = CMD_WRITE ? WR_REQ : RD_REQ;
            WR_REQ:  if (aw_fin && w_fin) state_nxt = WR_RESP;
            WR_RESP: if (AXI_M_BVALID && AXI_M_BREADY) state_nxt = RSP;
            RD_REQ:  if (AXI_M_ARVALID && AXI_M_ARREADY) state_nxt = RD_RESP;
            RD_RESP: if (AXI_M_RVALID && AXI_M_RREADY) state_nxt = RSP;
            RSP:     if (RSP_VALID && RSP_READY) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge AXI_M_ACLK or negedge AXI_M_ARESETn) begin
        if (!AXI_M_ARESETn) begin
            CMD_READY     <= 1'b0;
            RSP_VALID     <= 1'b0;
            RSP_WRITE     <= 1'b0;
            RSP_RDATA     <= '0;
            RSP_RESP      <= RESP_OKAY;
            AXI_M_AWVALID <= 1'b0;
            AXI_M_WVALID  <= 1'b0;
            AXI_M_BREADY  <= 1'b0;
            AXI_M_ARVALID <= 1'b0;
            AXI_M_RREADY  <= 1'b0;
            addr_q        <= '0;
            wdata_q       <= '0;
            wstrb_q       <= '0;
            aw_done       <= 1'b0;
            w_done        <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (cmd_acc) begin
                        CMD_READY <= 1'b0;
                        addr_q    <= CMD_ADDR;
                        wdata_q   <= CMD_WDATA;
                        wstrb_q   <= CMD_WSTRB;
                        RSP_WRITE <= CMD_WRITE;
                        aw_done   <= 1'b0;
                        w_done    <= 1'b0;
                        if (CMD_WRITE) begin
                            AXI_M_AWVALID <= 1'b1;
                            AXI_M_WVALID  <= 1'b1;
                        end else begin
                            AXI_M_ARVALID <= 1'b1;
                        end
                    end else begin
                        CMD_READY <= 1'b1;
                    end
                end
                WR_REQ: begin
                    if (aw_hs) begin
                        AXI_M_AWVALID <= 1'b0;
                        aw_done       <= 1'b1;
                    end
                    if (w_hs) begin
                        AXI_M_WVALID <= 1'b0;
                        w_done       <= 1'b1;
                    end
                    if (aw_fin && w_fin) AXI_M_BREADY <= 1'b1;
                end
                WR_RESP: begin
                    if (AXI_M_BVALID && AXI_M_BREADY) begin
                        AXI_M_BREADY <= 1'b0;
                        RSP_RESP     <= AXI_M_BRESP;
                        RSP_RDATA    <= '0;
                    end
                end
                RD_REQ: begin
                    if (AXI_M_ARVALID && AXI_M_ARREADY) begin
                        AXI_M_ARVALID <= 1'b0;
                        AXI_M_RREADY  <= 1'b1;
                    end
                end
                RD_RESP: begin
                    if (AXI_M_RVALID && AXI_M_RREADY) begin
                        AXI_M_RREADY <= 1'b0;
                        RSP_RESP     <= AXI_M_RRESP;
                        RSP_RDATA    <= AXI_M_RDATA;
                    end
                end
                RSP: begin
                    // RSP_VALID follows the state by one edge so every output stays registered.
                    if (!RSP_VALID) begin
                        RSP_VALID <= 1'b1;
                    end else if (RSP_READY) begin
                        RSP_VALID <= 1'b0;
                        CMD_READY <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_dft_axil_initiator.sv
// Directed bench for dft_axil_initiator: the bench plays the AXI-Lite slave and
// checks responses against a scoreboard queue filled when commands are issued.
module tb_dft_axil_initiator;
    import dft_axil_pkg::*;

    localparam int AW = 24;

    logic          clk, rst_n;
    logic          cmd_valid, cmd_ready, cmd_write;
    logic [AW-1:0] cmd_addr;
    logic [31:0]   cmd_wdata;
    logic [3:0]    cmd_wstrb;
    logic          rsp_valid, rsp_ready, rsp_write;
    logic [31:0]   rsp_rdata;
    logic [1:0]    rsp_resp;
    logic          awvalid, awready, wvalid, wready, bvalid, bready;
    logic          arvalid, arready, rvalid, rready;
    logic [AW-1:0] awaddr, araddr;
    logic [2:0]    awprot, arprot;
    logic [31:0]   wdata, rdata;
    logic [3:0]    wstrb;
    logic [1:0]    bresp, rresp;

    typedef struct {
        logic        w;
        logic [31:0] rdata;
        logic [1:0]  resp;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;
    int   bcnt   = 0;

    dft_axil_initiator #(.ADDR_WIDTH(AW), .PROT(3'b000)) dut (
        .AXI_M_ACLK(clk), .AXI_M_ARESETn(rst_n),
        .CMD_VALID(cmd_valid), .CMD_READY(cmd_ready), .CMD_WRITE(cmd_write),
        .CMD_ADDR(cmd_addr), .CMD_WDATA(cmd_wdata), .CMD_WSTRB(cmd_wstrb),
        .RSP_VALID(rsp_valid), .RSP_READY(rsp_ready), .RSP_WRITE(rsp_write),
        .RSP_RDATA(rsp_rdata), .RSP_RESP(rsp_resp),
        .AXI_M_AWVALID(awvalid), .AXI_M_AWREADY(awready), .AXI_M_AWADDR(awaddr),
        .AXI_M_AWPROT(awprot),
        .AXI_M_WVALID(wvalid), .AXI_M_WREADY(wready), .AXI_M_WDATA(wdata),
        .AXI_M_WSTRB(wstrb),
        .AXI_M_BVALID(bvalid), .AXI_M_BREADY(bready), .AXI_M_BRESP(bresp),
        .AXI_M_ARVALID(arvalid), .AXI_M_ARREADY(arready), .AXI_M_ARADDR(araddr),
        .AXI_M_ARPROT(arprot),
        .AXI_M_RVALID(rvalid), .AXI_M_RREADY(rready), .AXI_M_RDATA(rdata),
        .AXI_M_RRESP(rresp)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) if (bvalid && bready) bcnt++;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Present a command, wait for acceptance, check the request channel that follows.
    task automatic issue(input string tag, input logic w, input logic [AW-1:0] a,
                         input logic [31:0] d, input logic [3:0] s, input bit keep);
        int n;
        cmd_write = w; cmd_addr = a; cmd_wdata = d; cmd_wstrb = s; cmd_valid = 1'b1;
        n = 0;
        while (!cmd_ready && n < 50) begin tick(); n++; end
        chk({tag, "_cmd_ready"}, 32'(cmd_ready), 32'd1);
        tick();
        if (!keep) cmd_valid = 1'b0;
        chk({tag, "_cmd_ready_drop"}, 32'(cmd_ready), 32'd0);
        if (w) begin
            chk({tag, "_awvalid"}, 32'(awvalid), 32'd1);
            chk({tag, "_wvalid"}, 32'(wvalid), 32'd1);
            chk({tag, "_awaddr"}, 32'(awaddr), 32'(a));
            chk({tag, "_wdata"}, wdata, d);
            chk({tag, "_wstrb"}, 32'(wstrb), 32'(s));
        end else begin
            chk({tag, "_arvalid"}, 32'(arvalid), 32'd1);
            chk({tag, "_araddr"}, 32'(araddr), 32'(a));
        end
    endtask

    task automatic serve_wr(input string tag, input int aw_dly, input int w_dly,
                            input logic [1:0] br);
        bit awd, wd, hs_aw, hs_w;
        logic [AW-1:0] a0;
        int c;
        awd = 0; wd = 0; c = 0; a0 = awaddr;
        while (!(awd && wd) && c < 20) begin
            awready = (c >= aw_dly);
            wready  = (c >= w_dly);
            hs_aw = awvalid && awready;
            hs_w  = wvalid && wready;
            tick();
            if (hs_aw) awd = 1;
            if (hs_w)  wd  = 1;
            chk({tag, "_awvalid_hold"}, 32'(awvalid), 32'(!awd));
            chk({tag, "_wvalid_hold"}, 32'(wvalid), 32'(!wd));
            if (!awd) chk({tag, "_awaddr_stable"}, 32'(awaddr), 32'(a0));
            c++;
        end
        awready = 1'b0; wready = 1'b0;
        chk({tag, "_aw_w_done"}, 32'(awd && wd), 32'd1);
        chk({tag, "_bready"}, 32'(bready), 32'd1);
        bvalid = 1'b1; bresp = br;
        tick();
        bvalid = 1'b0; bresp = 2'b00;
        chk({tag, "_bready_drop"}, 32'(bready), 32'd0);
    endtask

    task automatic serve_rd(input string tag, input int r_dly, input logic [31:0] d,
                            input logic [1:0] rr);
        arready = 1'b1;
        tick();
        arready = 1'b0;
        chk({tag, "_arvalid_drop"}, 32'(arvalid), 32'd0);
        chk({tag, "_rready"}, 32'(rready), 32'd1);
        repeat (r_dly) begin
            tick();
            chk({tag, "_rready_wait"}, 32'(rready), 32'd1);
        end
        rvalid = 1'b1; rdata = d; rresp = rr;
        tick();
        rvalid = 1'b0; rdata = '0; rresp = 2'b00;
        chk({tag, "_rready_drop"}, 32'(rready), 32'd0);
    endtask

    // Wait for a response, compare against the scoreboard, optionally stall RSP_READY.
    task automatic wait_rsp(input string tag, input int hold);
        exp_t e;
        int n;
        n = 0;
        while (!rsp_valid && n < 50) begin tick(); n++; end
        chk({tag, "_rsp_valid"}, 32'(rsp_valid), 32'd1);
        if (exp_q.size() == 0) begin
            chk({tag, "_scoreboard_empty"}, 32'd0, 32'd1);
            return;
        end
        e = exp_q.pop_front();
        chk({tag, "_rsp_write"}, 32'(rsp_write), 32'(e.w));
        chk({tag, "_rsp_rdata"}, rsp_rdata, e.rdata);
        chk({tag, "_rsp_resp"}, 32'(rsp_resp), 32'(e.resp));
        repeat (hold) begin
            tick();
            chk({tag, "_rsp_hold_valid"}, 32'(rsp_valid), 32'd1);
            chk({tag, "_rsp_hold_resp"}, 32'(rsp_resp), 32'(e.resp));
            chk({tag, "_rsp_hold_rdata"}, rsp_rdata, e.rdata);
            chk({tag, "_cmd_ready_blocked"}, 32'(cmd_ready), 32'd0);
        end
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
        chk({tag, "_rsp_valid_drop"}, 32'(rsp_valid), 32'd0);
        chk({tag, "_cmd_ready_back"}, 32'(cmd_ready), 32'd1);
    endtask

    initial begin
        int b0;
        rst_n = 1'b0;
        cmd_valid = 0; cmd_write = 0; cmd_addr = '0; cmd_wdata = '0; cmd_wstrb = '0;
        rsp_ready = 0; awready = 0; wready = 0; bvalid = 0; bresp = '0;
        arready = 0; rvalid = 0; rdata = '0; rresp = '0;

        // Reset state
        #22;
        chk("rst_cmd_ready", 32'(cmd_ready), 32'd0);
        chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("rst_valids", {28'd0, awvalid, wvalid, arvalid, 1'b0}, 32'd0);
        chk("rst_readys", {30'd0, bready, rready}, 32'd0);
        chk("rst_rsp_rdata", rsp_rdata, 32'd0);
        chk("rst_awaddr", 32'(awaddr), 32'd0);
        @(negedge clk) rst_n = 1'b1;
        tick();
        chk("rel_cmd_ready", 32'(cmd_ready), 32'd1);

        // Stray responses while idle must be ignored
        rvalid = 1'b1; bvalid = 1'b1; rdata = 32'hFFFF_FFFF;
        tick(); tick();
        rvalid = 1'b0; bvalid = 1'b0; rdata = '0;
        chk("stray_rsp_valid", 32'(rsp_valid), 32'd0);
        tick();
        chk("stray_rsp_valid2", 32'(rsp_valid), 32'd0);

        // 1: zero-wait write, latency check
        exp_q.push_back('{1'b1, 32'd0, RESP_OKAY});
        issue("t1", 1'b1, 24'h000010, 32'hDEAD_BEEF, 4'hF, 1'b0);
        serve_wr("t1", 0, 0, RESP_OKAY);
        chk("t1_rsp_not_n2", 32'(rsp_valid), 32'd0);
        tick();
        chk("t1_rsp_at_n3", 32'(rsp_valid), 32'd1);
        wait_rsp("t1", 0);

        // 2: AWREADY late by 5 cycles, WREADY immediate, exactly one B handshake
        exp_q.push_back('{1'b1, 32'd0, RESP_OKAY});
        b0 = bcnt;
        issue("t2", 1'b1, 24'hABCDE4, 32'h0102_0304, 4'h3, 1'b0);
        serve_wr("t2", 5, 0, RESP_OKAY);
        wait_rsp("t2", 0);
        chk("t2_b_count", 32'(bcnt - b0), 32'd1);

        // 3: read with 3-cycle RVALID delay
        exp_q.push_back('{1'b0, 32'h1234_5678, RESP_OKAY});
        issue("t3", 1'b0, 24'h000020, 32'h0, 4'h0, 1'b0);
        serve_rd("t3", 3, 32'h1234_5678, RESP_OKAY);
        wait_rsp("t3", 0);

        // 4: SLVERR read, response stalled 4 cycles
        exp_q.push_back('{1'b0, 32'hCAFE_F00D, RESP_SLVERR});
        issue("t4", 1'b0, 24'h000044, 32'h0, 4'h0, 1'b0);
        serve_rd("t4", 0, 32'hCAFE_F00D, RESP_SLVERR);
        wait_rsp("t4", 4);

        // 5: back-to-back write then read with CMD_VALID held high
        exp_q.push_back('{1'b1, 32'd0, RESP_DECERR});
        exp_q.push_back('{1'b0, 32'h5A5A_A5A5, RESP_OKAY});
        issue("t5w", 1'b1, 24'h000100, 32'h1111_2222, 4'hC, 1'b1);
        cmd_write = 1'b0; cmd_addr = 24'h000104;
        serve_wr("t5w", 1, 2, RESP_DECERR);
        chk("t5_cmd_ready_busy", 32'(cmd_ready), 32'd0);
        wait_rsp("t5w", 0);
        chk("t5_no_early_ar", 32'(arvalid), 32'd0);
        issue("t5r", 1'b0, 24'h000104, 32'h0, 4'h0, 1'b0);
        serve_rd("t5r", 1, 32'h5A5A_A5A5, RESP_OKAY);
        wait_rsp("t5r", 0);

        // 6: reset while waiting for B
        exp_q.push_back('{1'b1, 32'd0, RESP_OKAY});
        issue("t6", 1'b1, 24'h000200, 32'h7777_8888, 4'hF, 1'b0);
        awready = 1'b1; wready = 1'b1;
        tick();
        awready = 1'b0; wready = 1'b0;
        chk("t6_in_wr_resp", 32'(bready), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        chk("t6_async_bready", 32'(bready), 32'd0);
        chk("t6_async_valids", {28'd0, awvalid, wvalid, arvalid, rready}, 32'd0);
        chk("t6_async_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("t6_async_cmd_ready", 32'(cmd_ready), 32'd0);
        exp_q.delete();
        @(negedge clk) rst_n = 1'b1;
        tick();
        chk("t6_rel_cmd_ready", 32'(cmd_ready), 32'd1);
        chk("t6_rel_rsp_valid", 32'(rsp_valid), 32'd0);
        repeat (3) tick();
        chk("t6_no_rsp", 32'(rsp_valid), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
